// File: rtl/eth_pkg.sv
// Shared constants, TX state encoding and the byte-wise CRC-32 step for the GMII framer/deframer pair.
package eth_pkg;

   localparam logic [7:0]  PREAMBLE_BYTE  = 8'h55;
   localparam logic [7:0]  SFD_BYTE       = 8'hD5;
   localparam logic [10:0] MIN_PAYLOAD    = 11'd46;
   localparam logic [10:0] MAX_PAYLOAD    = 11'd1500;
   localparam logic [10:0] IFG_BYTES      = 11'd12;
   localparam logic [10:0] PREAMBLE_BYTES = 11'd7;
   localparam logic [10:0] MAC_BYTES      = 11'd6;
   localparam logic [10:0] LEN_BYTES      = 11'd2;
   localparam logic [10:0] FCS_BYTES      = 11'd4;
   localparam logic [31:0] CRC_POLY       = 32'hEDB88320;
   localparam logic [31:0] CRC_INIT       = 32'hFFFFFFFF;

   typedef enum logic [3:0] {
      ST_IDLE, ST_PREAMBLE, ST_SFD, ST_DST, ST_SRC,
      ST_LEN, ST_PAYLOAD, ST_PAD, ST_FCS, ST_IFG
   } tx_state_t;

   // Reflected CRC-32, bits consumed LSB first.
   function automatic logic [31:0] crc32_next(input logic [31:0] crc, input logic [7:0] data);
      logic [31:0] c;
      c = crc;
      for (int i = 0; i < 8; i++) begin
         if (c[0] ^ data[i]) c = (c >> 1) ^ CRC_POLY;
         else                c = c >> 1;
      end
      return c;
   endfunction

endpackage

// File: rtl/eth_crc32_gen.sv
// Running FCS register: cleared by init, advanced one byte per enabled cycle.
module eth_crc32_gen
   import eth_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        init,
   input  logic        en,
   input  logic [7:0]  data,
   output logic [31:0] crc
);

   always_ff @(posedge clk) begin
      if (rst || init) crc <= CRC_INIT;
      else if (en)     crc <= crc32_next(crc, data);
   end

endmodule

// File: rtl/ethernet_encapsulation.sv
// GMII transmit framer: preamble/SFD, MAC header, length, payload from FIFO, pad, FCS, then IFG.
module ethernet_encapsulation
   import eth_pkg::*;
#(
   parameter logic [47:0] destination_mac_addr = 48'h023528fbdd66,
   parameter logic [47:0] source_mac_addr      = 48'h072227acdb65
)
(
   input  logic        eth_tx_clk,
   input  logic        eth_rst,
   input  logic        pct_qued,
   input  logic [10:0] pct_len,
   input  logic [7:0]  ff_out_data_in,
   output logic        bf_in_r_en,
   output logic        bf_in_pct_txed,
   output logic        len_err,
   output logic        tx_busy,
   output logic [7:0]  gmii_tx_d,
   output logic        gmii_tx_en,
   output logic        gmii_tx_er
);

   tx_state_t   state, nxt_state;
   logic [10:0] cnt, nxt_cnt, len_q, pad_len;
   logic        decide, start_ok, lerr_nxt;
   logic [7:0]  d_nxt;
   logic        en_nxt, ren_nxt, txed_nxt, crc_init, crc_en;
   logic [31:0] crc, fcs;

   function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] idx);
      case (idx)
         3'd0:    return mac[47:40];
         3'd1:    return mac[39:32];
         3'd2:    return mac[31:24];
         3'd3:    return mac[23:16];
         3'd4:    return mac[15:8];
         3'd5:    return mac[7:0];
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [7:0] fcs_byte(input logic [31:0] f, input logic [1:0] idx);
      case (idx)
         2'd0:    return f[7:0];
         2'd1:    return f[15:8];
         2'd2:    return f[23:16];
         default: return f[31:24];
      endcase
   endfunction

   assign pad_len = (len_q < MIN_PAYLOAD) ? (MIN_PAYLOAD - len_q) : 11'd0;
   assign fcs     = ~crc;

   // state/cnt name the byte currently on the wire; the last IFG byte doubles as an IDLE decision
   always_comb begin
      nxt_state = state;
      nxt_cnt   = cnt + 11'd1;
      lerr_nxt  = 1'b0;
      start_ok  = (pct_len != 11'd0) && (pct_len <= MAX_PAYLOAD);
      decide    = (state == ST_IDLE) || ((state == ST_IFG) && (cnt == IFG_BYTES - 11'd1));
      case (state)
         ST_PREAMBLE: if (cnt == PREAMBLE_BYTES - 11'd1) nxt_state = ST_SFD;
         ST_SFD:      nxt_state = ST_DST;
         ST_DST:      if (cnt == MAC_BYTES - 11'd1) nxt_state = ST_SRC;
         ST_SRC:      if (cnt == MAC_BYTES - 11'd1) nxt_state = ST_LEN;
         ST_LEN:      if (cnt == LEN_BYTES - 11'd1) nxt_state = ST_PAYLOAD;
         ST_PAYLOAD:  if (cnt == len_q - 11'd1)
                         nxt_state = (len_q < MIN_PAYLOAD) ? ST_PAD : ST_FCS;
         ST_PAD:      if (cnt == pad_len - 11'd1) nxt_state = ST_FCS;
         ST_FCS:      if (cnt == FCS_BYTES - 11'd1) nxt_state = ST_IFG;
         ST_IFG:      if (cnt == IFG_BYTES - 11'd1) nxt_state = ST_IDLE;
         default:     nxt_state = ST_IDLE;
      endcase
      if (decide && pct_qued) begin
         if (start_ok) nxt_state = ST_PREAMBLE;
         else          lerr_nxt  = 1'b1;
      end
      if ((nxt_state != state) || (nxt_state == ST_IDLE)) nxt_cnt = 11'd0;
   end

   // Outputs are precomputed for the next wire byte, so the FIFO byte presented during a
   // strobe cycle lands on gmii_tx_d in the following cycle.
   always_comb begin
      d_nxt    = 8'h00;
      en_nxt   = 1'b1;
      ren_nxt  = 1'b0;
      txed_nxt = 1'b0;
      crc_init = 1'b0;
      crc_en   = 1'b0;
      case (nxt_state)
         ST_PREAMBLE: begin d_nxt = PREAMBLE_BYTE; crc_init = 1'b1; end
         ST_SFD:      d_nxt = SFD_BYTE;
         ST_DST:      begin d_nxt = mac_byte(destination_mac_addr, nxt_cnt[2:0]); crc_en = 1'b1; end
         ST_SRC:      begin d_nxt = mac_byte(source_mac_addr, nxt_cnt[2:0]); crc_en = 1'b1; end
         ST_LEN: begin
            d_nxt   = (nxt_cnt == 11'd0) ? {5'b0, len_q[10:8]} : len_q[7:0];
            crc_en  = 1'b1;
            ren_nxt = (nxt_cnt == 11'd1);
         end
         ST_PAYLOAD: begin
            d_nxt   = ff_out_data_in;
            crc_en  = 1'b1;
            ren_nxt = (nxt_cnt < len_q - 11'd1);
         end
         ST_PAD:      crc_en = 1'b1;
         ST_FCS: begin
            d_nxt    = fcs_byte(fcs, nxt_cnt[1:0]);
            txed_nxt = (nxt_cnt == FCS_BYTES - 11'd1);
         end
         default:     en_nxt = 1'b0;
      endcase
   end

   always_ff @(posedge eth_tx_clk) begin
      if (eth_rst) begin
         state          <= ST_IDLE;
         cnt            <= 11'd0;
         len_q          <= 11'd0;
         gmii_tx_d      <= 8'h00;
         gmii_tx_en     <= 1'b0;
         gmii_tx_er     <= 1'b0;
         bf_in_r_en     <= 1'b0;
         bf_in_pct_txed <= 1'b0;
         len_err        <= 1'b0;
         tx_busy        <= 1'b0;
      end else begin
         state          <= nxt_state;
         cnt            <= nxt_cnt;
         if (decide && pct_qued && start_ok) len_q <= pct_len;
         gmii_tx_d      <= d_nxt;
         gmii_tx_en     <= en_nxt;
         gmii_tx_er     <= 1'b0;
         bf_in_r_en     <= ren_nxt;
         bf_in_pct_txed <= txed_nxt;
         len_err        <= lerr_nxt;
         tx_busy        <= (nxt_state != ST_IDLE);
      end
   end

   eth_crc32_gen u_crc (
      .clk  (eth_tx_clk),
      .rst  (eth_rst),
      .init (crc_init),
      .en   (crc_en),
      .data (d_nxt),
      .crc  (crc)
   );

endmodule
